// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
// Command-driven controller for a bank of WIDTH JK flip-flops that share clk.
// A host issues HOLD / CLEAR / LOAD / COUNT over a valid/ready handshake; the
// controller drives per-bit J/K vectors and observes the bank's Q on q_in.
// J/K are combinational from registered state and q_in so the bank reacts on
// the same edge that advances the controller, and they are gated by rst_n so
// the bank holds its contents while the controller is being reset.

module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_COUNT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_COUNT = 2'b10
    } state_t;

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [WIDTH-1:0] tmask;

    // Toggle mask of a synchronous binary counter built from JK stages:
    // bit i toggles when every lower bit is 1 (counting up) or 0 (counting
    // down). Bit 0 always toggles, which also gives natural wrap-around.
    function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] q,
                                                     input logic             up);
        logic [WIDTH-1:0] m;
        logic             carry;
        m     = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i]  = carry;
            carry = carry & (up ? q[i] : ~q[i]);
        end
        return m;
    endfunction

    assign tmask     = toggle_mask(q_in, dir);
    assign cmd_ready = rst_n && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Drive the bank: J/K follow the current state, forced to hold during reset.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (rst_n) begin
            case (state)
                ST_EXEC: begin
                    if (op == OP_CLEAR) begin
                        j_out = '0;
                        k_out = '1;
                    end else if (op == OP_LOAD) begin
                        j_out = data;
                        k_out = ~data;
                    end
                end
                ST_COUNT: begin
                    j_out = tmask;
                    k_out = tmask;
                end
                default: begin
                    j_out = '0;
                    k_out = '0;
                end
            endcase
        end
    end

    // Command FSM: accept in IDLE, one EXEC cycle for CLEAR/LOAD, N cycles of COUNT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            steps_left <= '0;
            op         <= OP_HOLD;
            data       <= '0;
            dir        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op         <= cmd_op;
                        data       <= cmd_data;
                        dir        <= cmd_dir;
                        steps_left <= cmd_steps;
                        case (cmd_op)
                            OP_HOLD: begin
                                done <= 1'b1;
                            end
                            OP_CLEAR, OP_LOAD: begin
                                state <= ST_EXEC;
                            end
                            OP_COUNT: begin
                                if (cmd_steps == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    state <= ST_COUNT;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                ST_COUNT: begin
                    steps_left <= steps_left - CNT_W'(1);
                    if (steps_left == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a 4-bit JK bank model is attached to the DUT,
// a transaction-level model predicts the controller outputs every cycle, and
// directed scenarios pin the expected bank values with literals.

module tb_jk_bank_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_COUNT = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic [WIDTH-1:0] q_bank;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .q_in       (q_bank),
        .j_out      (j_out),
        .k_out      (k_out),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    // The controlled bank: four JK flip-flops, never reset.
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_out[i], k_out[i]})
                2'b01:   q_bank[i] <= 1'b0;
                2'b10:   q_bank[i] <= 1'b1;
                2'b11:   q_bank[i] <= ~q_bank[i];
                default: q_bank[i] <= q_bank[i];
            endcase
        end
    end

    // Transaction model: m_cnt = cycles of J/K activity still owed by the
    // current command; done follows the cycle in which that activity ends.
    int               m_cnt = 0;
    logic [1:0]       m_op = 2'b00;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_dir = 1'b0;
    logic [CNT_W-1:0] m_steps = '0;
    logic             m_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_done  <= 1'b0;
            m_steps <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (cmd_valid) begin
                m_op    <= cmd_op;
                m_data  <= cmd_data;
                m_dir   <= cmd_dir;
                m_steps <= cmd_steps;
                if (cmd_op == OP_CLEAR || cmd_op == OP_LOAD)
                    m_cnt <= 1;
                else if (cmd_op == OP_COUNT && cmd_steps != 0)
                    m_cnt <= int'(cmd_steps);
                else
                    m_done <= 1'b1;
            end
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_op == OP_COUNT) m_steps <= m_steps - 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            logic [WIDTH-1:0] nxt;
            logic [WIDTH-1:0] ej;
            logic [WIDTH-1:0] ek;
            ej = '0;
            ek = '0;
            if (rst_n && m_cnt > 0) begin
                if (m_op == OP_CLEAR) begin
                    ek = '1;
                end else if (m_op == OP_LOAD) begin
                    ej = m_data;
                    ek = ~m_data;
                end else if (m_op == OP_COUNT) begin
                    nxt = m_dir ? q_bank + 1'b1 : q_bank - 1'b1;
                    ej  = q_bank ^ nxt;
                    ek  = ej;
                end
            end
            check("cyc_ready", 32'(cmd_ready), 32'(rst_n && m_cnt == 0));
            check("cyc_busy", 32'(busy), 32'(m_cnt != 0));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_steps_left", 32'(steps_left), 32'(m_steps));
            check("cyc_j", 32'(j_out), 32'(ej));
            check("cyc_k", 32'(k_out), 32'(ek));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one time step after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input logic [CNT_W-1:0] n, input logic up);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL issue_timeout: cmd_ready stayed 0 expected 1");
        end
        cmd_op    = op;
        cmd_data  = d;
        cmd_steps = n;
        cmd_dir   = up;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_steps = '0;
    endtask

    logic [WIDTH-1:0] up_seq [5];
    logic [WIDTH-1:0] dn_seq [3];
    int busy_cycles;

    initial begin
        up_seq = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
        dn_seq = '{4'b1111, 4'b1110, 4'b1101};

        rst_n = 1'b0;
        tick();
        started = 1'b1;
        check("reset_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("reset_done", 32'(done), 32'd0);
        check("reset_steps", 32'(steps_left), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_release_ready", 32'(cmd_ready), 32'd1);

        // CLEAR from an undefined bank
        issue(OP_CLEAR, 4'b0000, 8'd0, 1'b0);
        check("clear_exec_ready", 32'(cmd_ready), 32'd0);
        check("clear_exec_k", 32'(k_out), 32'hF);
        tick();
        check("clear_q", 32'(q_bank), 32'h0);
        check("clear_done", 32'(done), 32'd1);
        check("clear_ready_back", 32'(cmd_ready), 32'd1);
        tick();
        check("clear_done_width", 32'(done), 32'd0);

        // LOAD 1010: one cycle of J/K
        issue(OP_LOAD, 4'b1010, 8'd0, 1'b0);
        check("load_j", 32'(j_out), 32'hA);
        check("load_k", 32'(k_out), 32'h5);
        tick();
        check("load_j_after", 32'(j_out), 32'h0);
        check("load_q", 32'(q_bank), 32'hA);
        check("load_done", 32'(done), 32'd1);
        tick();

        // LOAD 1101 then COUNT up 5 with wrap
        issue(OP_LOAD, 4'b1101, 8'd0, 1'b0);
        tick();
        issue(OP_COUNT, 4'b0000, 8'd5, 1'b1);
        check("up_steps_start", 32'(steps_left), 32'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("up_q", 32'(q_bank), 32'(up_seq[i]));
            check("up_steps", 32'(steps_left), 32'(4 - i));
            check("up_done", 32'(done), 32'(i == 4));
        end
        tick();

        // CLEAR then COUNT down 3 with wrap
        issue(OP_CLEAR, 4'b0000, 8'd0, 1'b0);
        tick();
        tick();
        issue(OP_COUNT, 4'b0000, 8'd3, 1'b0);
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dn_q", 32'(q_bank), 32'(dn_seq[i]));
            if (busy) busy_cycles++;
        end
        check("dn_busy_cycles", 32'(busy_cycles), 32'd3);
        check("dn_done", 32'(done), 32'd1);
        tick();

        // HOLD, then COUNT 0 accepted on the done cycle
        issue(OP_HOLD, 4'b0000, 8'd0, 1'b0);
        check("hold_done", 32'(done), 32'd1);
        check("hold_j", 32'(j_out), 32'h0);
        check("hold_q", 32'(q_bank), 32'hD);
        issue(OP_COUNT, 4'b0000, 8'd0, 1'b1);
        check("cnt0_done", 32'(done), 32'd1);
        check("cnt0_q", 32'(q_bank), 32'hD);
        tick();
        check("cnt0_done_end", 32'(done), 32'd0);

        // Reset in the middle of COUNT up 10
        issue(OP_CLEAR, 4'b0000, 8'd0, 1'b0);
        tick();
        issue(OP_COUNT, 4'b0000, 8'd10, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("mid_q", 32'(q_bank), 32'h4);
        check("mid_steps", 32'(steps_left), 32'd6);
        rst_n = 1'b0;
        #1;
        check("rst_j", 32'(j_out), 32'h0);
        check("rst_k", 32'(k_out), 32'h0);
        tick();
        check("rst_q_frozen", 32'(q_bank), 32'h4);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_steps", 32'(steps_left), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("rst_no_done", 32'(done), 32'd0);
        check("rst_q_hold", 32'(q_bank), 32'h4);

        tick();
        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
